// File: rtl/softmax_norm_buffer_if.sv
// Handshake/data bundle for softmax_norm_buffer.
//   Exp input stream   : i_valid, i_exp, o_ready
//   Reciprocal request : o_sum_valid, o_sum
//   Reciprocal return  : i_recip_valid, i_reciprocal
//   Probability stream : o_prob_valid, o_prob, o_last
// Signal directions are named from the block's point of view. The slave
// modport is the block itself; the master modport is its environment.
interface softmax_norm_buffer_if #(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned BIT_WIDTH = 16
);
  logic                 i_valid;
  logic [IN_WIDTH-1:0]  i_exp;
  logic                 o_ready;
  logic                 o_sum_valid;
  logic [IN_WIDTH-1:0]  o_sum;
  logic                 i_recip_valid;
  logic [BIT_WIDTH-1:0] i_reciprocal;
  logic                 o_prob_valid;
  logic [BIT_WIDTH-1:0] o_prob;
  logic                 o_last;

  modport slave (
    input  i_valid, i_exp, i_recip_valid, i_reciprocal,
    output o_ready, o_sum_valid, o_sum, o_prob_valid, o_prob, o_last
  );

  modport master (
    output i_valid, i_exp, i_recip_valid, i_reciprocal,
    input  o_ready, o_sum_valid, o_sum, o_prob_valid, o_prob, o_last
  );
endinterface

// File: rtl/softmax_norm_buffer.sv
// Softmax back end: buffers one vector of N exp() values (Q6.26) while
// accumulating their saturating sum, hands the sum to an external reciprocal
// unit, then scales every buffered exp by the returned reciprocal (Q0.16) and
// streams N probabilities (Q0.16).
// Ports:
//   i_clk  - clock
//   i_rst  - asynchronous reset, active high
//   bus_io - softmax_norm_buffer_if.slave (exp in, sum out, reciprocal in,
//            probability out)
module softmax_norm_buffer #(
  parameter int unsigned N         = 32,
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned BIT_WIDTH = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  softmax_norm_buffer_if.slave      bus_io
);

  localparam int unsigned CntW   = $clog2(N);
  localparam int unsigned ProdW  = IN_WIDTH + BIT_WIDTH;
  // Exp has 6 integer bits; the product keeps the same 6 integer bits on top.
  localparam int unsigned FracIn = IN_WIDTH - 6;
  localparam logic [CntW-1:0] LastIdx = CntW'(N - 1);

  typedef enum logic [1:0] {StAccum, StSend, StWait, StNorm} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [CntW-1:0]      idx_q, idx_d;
  logic [IN_WIDTH-1:0]  sum_q, sum_d;
  logic [IN_WIDTH-1:0]  sum_out_q, sum_out_d;
  logic [BIT_WIDTH-1:0] recip_q, recip_d;
  logic [BIT_WIDTH-1:0] prob_q, prob_d;
  logic                 prob_valid_q, prob_valid_d;
  logic                 last_q, last_d;

  logic [IN_WIDTH-1:0]  buf_q [N];
  logic                 buf_we;
  logic [IN_WIDTH:0]    sum_ext;
  logic [IN_WIDTH-1:0]  sum_sat;
  logic [ProdW-1:0]     prod;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    sum_d        = sum_q;
    sum_out_d    = sum_out_q;
    recip_d      = recip_q;
    prob_d       = '0;
    prob_valid_d = 1'b0;
    last_d       = 1'b0;
    buf_we       = 1'b0;

    sum_ext = {1'b0, sum_q} + {1'b0, bus_io.i_exp};
    sum_sat = sum_ext[IN_WIDTH] ? '1 : sum_ext[IN_WIDTH-1:0];
    prod    = ProdW'(buf_q[idx_q]) * ProdW'(recip_q);

    unique case (state_q)
      StAccum: begin
        if (bus_io.i_valid) begin
          buf_we = 1'b1;
          sum_d  = sum_sat;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LastIdx) begin
            state_d   = StSend;
            sum_out_d = sum_sat;
            cnt_d     = '0;
          end
        end
      end
      StSend: state_d = StWait;
      StWait: begin
        if (bus_io.i_recip_valid) begin
          recip_d = bus_io.i_reciprocal;
          idx_d   = '0;
          state_d = StNorm;
        end
      end
      StNorm: begin
        prob_valid_d = 1'b1;
        // Any set integer bit means the probability reached 1.0 or more.
        prob_d = (|prod[ProdW-1:FracIn+BIT_WIDTH]) ? '1 : prod[FracIn+BIT_WIDTH-1:FracIn];
        last_d = (idx_q == LastIdx);
        idx_d  = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          state_d = StAccum;
          idx_d   = '0;
          cnt_d   = '0;
          sum_d   = '0;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= StAccum;
      cnt_q        <= '0;
      idx_q        <= '0;
      sum_q        <= '0;
      sum_out_q    <= '0;
      recip_q      <= '0;
      prob_q       <= '0;
      prob_valid_q <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      sum_q        <= sum_d;
      sum_out_q    <= sum_out_d;
      recip_q      <= recip_d;
      prob_q       <= prob_d;
      prob_valid_q <= prob_valid_d;
      last_q       <= last_d;
    end
  end

  // Data storage only; never read before being written for the current vector.
  always_ff @(posedge i_clk) begin
    if (buf_we) buf_q[cnt_q] <= bus_io.i_exp;
  end

  assign bus_io.o_ready      = (state_q == StAccum) && !i_rst;
  assign bus_io.o_sum_valid  = (state_q == StSend);
  assign bus_io.o_sum        = sum_out_q;
  assign bus_io.o_prob_valid = prob_valid_q;
  assign bus_io.o_prob       = prob_q;
  assign bus_io.o_last       = last_q;

endmodule
